// File: rtl/axi_vector_pkg.sv
// Shared types and helpers for the stream<->vector converters (reader and writer sides).
package axi_vector_pkg;

  typedef enum logic [1:0] {
    STATE__IDLE       = 2'd0,
    STATE__READ_CHUNK = 2'd1,
    STATE__DONE       = 2'd2
  } state_t;

  // Number of den-bit chunks needed to cover num bits.
  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/axi_stream_if.sv
// Minimal AXI-Stream bundle: tvalid/tready handshake with tdata and tlast.
interface axi_stream_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [DATA_WIDTH-1:0] tdata;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/vector_tail_mask.sv
// Keep mask for one data slice: bit b is set when chunk_iter*W + b lies below the latched length.
module vector_tail_mask #(
  parameter int MAX_VEC_LENGTH = 64,
  parameter int AXI_DATA_WIDTH = 32,
  localparam int LEN_W      = (MAX_VEC_LENGTH <= 1) ? 1 : $clog2(MAX_VEC_LENGTH + 1),
  localparam int MAX_CHUNKS = (MAX_VEC_LENGTH + AXI_DATA_WIDTH - 1) / AXI_DATA_WIDTH,
  localparam int CHUNK_W    = (MAX_CHUNKS <= 1) ? 1 : $clog2(MAX_CHUNKS + 1)
) (
  input  logic [CHUNK_W-1:0]        chunk_iter_i,
  input  logic [LEN_W-1:0]          len_i,
  output logic [AXI_DATA_WIDTH-1:0] keep_o
);

  always_comb begin
    keep_o = '0;
    for (int b = 0; b < AXI_DATA_WIDTH; b++) begin
      keep_o[b] = ((int'(chunk_iter_i) * AXI_DATA_WIDTH + b) < int'(len_i));
    end
  end

endmodule

// File: rtl/axi_read_vector.sv
// Stream-to-vector deserializer: packs the first vec_length bits of an AXI-Stream
// into a parallel vector, LSB chunk first, and flags how tlast framed the read.
module axi_read_vector
  import axi_vector_pkg::*;
#(
  parameter int MAX_VEC_LENGTH   = 64,
  parameter int AXI_DATA_WIDTH   = 32,
  parameter int MAX_VEC_LENGTH_W = (MAX_VEC_LENGTH <= 1) ? 1 : $clog2(MAX_VEC_LENGTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [MAX_VEC_LENGTH_W-1:0] vec_length,
  output logic                        ready,
  output logic [MAX_VEC_LENGTH-1:0]   vec,
  output logic                        last_seen,
  output logic                        early_last,
  axi_stream_if.slave                 data_in,
  output state_t                      dbg_state
);

  localparam int MAX_CHUNKS = int'(ceil_div(MAX_VEC_LENGTH, AXI_DATA_WIDTH));
  localparam int CHUNK_W    = (MAX_CHUNKS <= 1) ? 1 : $clog2(MAX_CHUNKS + 1);
  localparam int LEN_W      = MAX_VEC_LENGTH_W;

  state_t                    state_q, state_d;
  logic [CHUNK_W-1:0]        chunk_iter_q, chunk_iter_d;
  logic [LEN_W-1:0]          len_q, len_d;
  logic [MAX_VEC_LENGTH-1:0] vec_q, vec_d;
  logic                      last_seen_q, last_seen_d;
  logic                      early_last_q, early_last_d;

  logic [LEN_W-1:0]          len_start;
  logic [CHUNK_W-1:0]        total;
  logic                      last_chunk;
  logic                      beat_acc;
  logic [AXI_DATA_WIDTH-1:0] keep;
  logic [MAX_VEC_LENGTH-1:0] wide_data;
  logic [MAX_VEC_LENGTH-1:0] in_slice;

  // A beat transfers on any posedge where tvalid && tready; tready depends only on
  // state_q, so there is no combinational path from tvalid back to tready.
  assign data_in.tready = (state_q == STATE__READ_CHUNK);
  assign beat_acc       = (state_q == STATE__READ_CHUNK) && data_in.tvalid;

  always_comb begin
    len_start = vec_length;
    if (vec_length > LEN_W'(MAX_VEC_LENGTH)) begin
      len_start = LEN_W'(MAX_VEC_LENGTH);
    end
  end

  assign total      = CHUNK_W'(ceil_div(32'(len_q), AXI_DATA_WIDTH));
  assign last_chunk = (chunk_iter_q == (total - CHUNK_W'(1)));

  vector_tail_mask #(
    .MAX_VEC_LENGTH (MAX_VEC_LENGTH),
    .AXI_DATA_WIDTH (AXI_DATA_WIDTH)
  ) u_tail_mask (
    .chunk_iter_i (chunk_iter_q),
    .len_i        (len_q),
    .keep_o       (keep)
  );

  // Replicate the masked beat across the vector; in_slice selects the current chunk,
  // and slice bits past MAX_VEC_LENGTH simply have no destination.
  for (genvar i = 0; i < MAX_VEC_LENGTH; i++) begin : g_bit
    assign wide_data[i] = data_in.tdata[i % AXI_DATA_WIDTH] & keep[i % AXI_DATA_WIDTH];
    assign in_slice[i]  = (CHUNK_W'(i / AXI_DATA_WIDTH) == chunk_iter_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= STATE__IDLE;
      chunk_iter_q <= '0;
      len_q        <= '0;
      vec_q        <= '0;
      last_seen_q  <= 1'b0;
      early_last_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      chunk_iter_q <= chunk_iter_d;
      len_q        <= len_d;
      vec_q        <= vec_d;
      last_seen_q  <= last_seen_d;
      early_last_q <= early_last_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    chunk_iter_d = chunk_iter_q;
    len_d        = len_q;
    vec_d        = vec_q;
    last_seen_d  = last_seen_q;
    early_last_d = early_last_q;
    case (state_q)
      STATE__IDLE: begin
        if (start) begin
          len_d        = len_start;
          chunk_iter_d = '0;
          vec_d        = '0;
          last_seen_d  = 1'b0;
          early_last_d = 1'b0;
          state_d      = (len_start == '0) ? STATE__DONE : STATE__READ_CHUNK;
        end
      end
      STATE__READ_CHUNK: begin
        if (beat_acc) begin
          vec_d = (vec_q & ~in_slice) | (wide_data & in_slice);
          if (last_chunk) begin
            last_seen_d = data_in.tlast;
            state_d     = STATE__DONE;
          end else if (data_in.tlast) begin
            early_last_d = 1'b1;
            state_d      = STATE__DONE;
          end else begin
            chunk_iter_d = chunk_iter_q + CHUNK_W'(1);
          end
        end
      end
      STATE__DONE: begin
        state_d = STATE__IDLE;
      end
      default: begin
        state_d = STATE__IDLE;
      end
    endcase
  end

  assign ready      = (state_q == STATE__DONE);
  assign vec        = vec_q;
  assign last_seen  = last_seen_q;
  assign early_last = early_last_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_axi_read_vector.sv
// Scoreboarded bench for axi_read_vector (10-bit vector, 4-bit stream).
module tb_axi_read_vector;
  import axi_vector_pkg::*;

  localparam int MAXV = 10;
  localparam int AW   = 4;
  localparam int LW   = 4;
  localparam int MAXC = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [LW-1:0]   vec_length;
  logic            ready;
  logic [MAXV-1:0] vec;
  logic            last_seen;
  logic            early_last;
  state_t          dbg_state;

  axi_stream_if #(.DATA_WIDTH(AW)) s_if ();

  axi_read_vector #(
    .MAX_VEC_LENGTH (MAXV),
    .AXI_DATA_WIDTH (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .vec_length (vec_length),
    .ready      (ready),
    .vec        (vec),
    .last_seen  (last_seen),
    .early_last (early_last),
    .data_in    (s_if),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  // entry: {latency[7:0], beats[3:0], last_seen, early_last, vec[9:0]}
  logic [23:0] exp_q[$];
  int          start_q[$];
  int          acc = 0;
  logic [23:0] mon_e;
  int          mon_sc;

  logic [AW-1:0] beat_data[MAXC];
  logic          beat_last[MAXC];
  int            beat_gap[MAXC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: concatenate the beats the stream would deliver, cut at the first tlast
  // or at the chunk count, then keep only the low L bits.
  function automatic logic [23:0] model(input int len);
    int     L, n, fl, cons, lat;
    logic   ls, el;
    longint acc_v;
    logic [MAXV-1:0] v;
    L  = (len > MAXV) ? MAXV : len;
    n  = (L + AW - 1) / AW;
    fl = n;
    for (int k = n - 1; k >= 0; k--) if (beat_last[k]) fl = k;
    cons  = (fl < n) ? fl + 1 : n;
    el    = (fl < n - 1);
    ls    = (n > 0) && (fl == n - 1);
    acc_v = 0;
    lat   = cons + 1;
    for (int k = 0; k < cons; k++) begin
      acc_v = acc_v | (longint'(beat_data[k]) << (AW * k));
      lat   = lat + beat_gap[k];
    end
    v = MAXV'(acc_v & ((longint'(1) << L) - 1));
    return {8'(lat), 4'(cons), ls, el, v};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      acc = 0;
    end else begin
      if (ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ready", 32'(1), 32'(0));
        end else begin
          mon_e  = exp_q.pop_front();
          mon_sc = start_q.pop_front();
          check("vec",        32'(vec),        32'(mon_e[9:0]));
          check("early_last", 32'(early_last), 32'(mon_e[10]));
          check("last_seen",  32'(last_seen),  32'(mon_e[11]));
          check("beats",      32'(acc),        32'(mon_e[15:12]));
          check("latency",    32'(cyc - mon_sc), 32'(mon_e[23:16]));
        end
        acc = 0;
      end
      if (s_if.tvalid && s_if.tready) acc++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_beats(input logic [AW-1:0] d0, d1, d2,
                           input logic l0, l1, l2, input int g0, g1, g2);
    beat_data[0] = d0; beat_data[1] = d1; beat_data[2] = d2;
    beat_last[0] = l0; beat_last[1] = l1; beat_last[2] = l2;
    beat_gap[0]  = g0; beat_gap[1]  = g1; beat_gap[2]  = g2;
  endtask

  task automatic run_read(input int len);
    int   k, gapleft;
    logic hs, done;
    @(posedge clk); #1;
    start      = 1'b1;
    vec_length = LW'(len);
    exp_q.push_back(model(len));
    start_q.push_back(cyc);
    @(posedge clk); #1;
    start   = 1'b0;
    k       = 0;
    gapleft = beat_gap[0];
    done    = 1'b0;
    for (int budget = 0; budget < 40 && !done; budget++) begin
      if (k < MAXC && gapleft == 0) begin
        s_if.tvalid = 1'b1;
        s_if.tdata  = beat_data[k];
        s_if.tlast  = beat_last[k];
      end else begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = AW'($urandom_range(0, 15));
        s_if.tlast  = 1'b0;
      end
      @(negedge clk);
      if (!s_if.tready) begin
        done = 1'b1;
      end else begin
        hs = s_if.tvalid;
        @(posedge clk); #1;
        if (hs) begin
          k++;
          gapleft = (k < MAXC) ? beat_gap[k] : 0;
        end else if (gapleft > 0) begin
          gapleft--;
        end
      end
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    if (!done) begin
      check("read_timeout", 32'(0), 32'(1));
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      start_q.delete();
    end
    repeat ($urandom_range(1, 3)) @(posedge clk);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_state"}, 32'(dbg_state),    32'(STATE__IDLE));
    check({tag, "_vec"},   32'(vec),          32'(0));
    check({tag, "_flags"}, 32'({last_seen, early_last}), 32'(0));
    check({tag, "_ready"}, 32'(ready),        32'(0));
    check({tag, "_tready"}, 32'(s_if.tready), 32'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    vec_length  = '0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // full length, tlast on final chunk
    set_beats(4'hA, 4'h5, 4'hF, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    run_read(10);
    // partial last chunk, no tlast
    set_beats(4'h3, 4'hF, 4'hC, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    run_read(6);
    // zero length: no beats consumed
    set_beats(4'h1, 4'h2, 4'h3, 1'b1, 1'b1, 1'b1, 0, 0, 0);
    run_read(0);
    // early tlast on first beat
    set_beats(4'h7, 4'h1, 4'h2, 1'b1, 1'b0, 1'b0, 0, 0, 0);
    run_read(10);
    // tvalid 1,0,0,1
    set_beats(4'hB, 4'hD, 4'h6, 1'b0, 1'b0, 1'b0, 0, 2, 0);
    run_read(8);
    // length above maximum clips to 10
    set_beats(4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 1, 0, 1);
    run_read(15);

    // reset in the middle of a 3-beat read
    @(posedge clk); #1;
    start      = 1'b1;
    vec_length = LW'(10);
    @(posedge clk); #1;
    start       = 1'b0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = 4'hA;
    s_if.tlast  = 1'b0;
    @(posedge clk); #1;
    s_if.tvalid = 1'b0;
    check("pre_reset_vec", 32'(vec), 32'(10'h00A));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_cleared("midrst");
    set_beats(4'h9, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    run_read(4);

    // randomized reads
    repeat (40) begin
      for (int k = 0; k < MAXC; k++) begin
        beat_data[k] = AW'($urandom_range(0, 15));
        beat_last[k] = ($urandom_range(0, 3) == 0);
        beat_gap[k]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      end
      run_read(int'($urandom_range(0, 15)));
    end

    repeat (4) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_read_vector.md
Name: axi_read_vector

Overview:
- Stream-to-vector deserializer. Sits directly upstream of axi_write_vector in the puzzle-processing datapath.
- Consumes AXI-Stream beats of AXI_DATA_WIDTH bits and assembles the first vec_length bits into a parallel vector, LSB chunk first.
- Reports completion, whether tlast closed the vector, and any early-tlast framing error.

Parameters:
- MAX_VEC_LENGTH, 64: maximum vector length in bits; width of vec.
- AXI_DATA_WIDTH, 32: tdata width in bits.
- MAX_VEC_LENGTH_W, (MAX_VEC_LENGTH<=1 ? 1 : $clog2(MAX_VEC_LENGTH+1)): width of vec_length.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a read; sampled only in IDLE.
- vec_length  in  MAX_VEC_LENGTH_W  bits to read; latched on accepted start.
- ready  out  1  one-cycle pulse in DONE; vec and flags are valid.
- vec  out  MAX_VEC_LENGTH  assembled vector; bits at index >= latched length read as 0.
- last_seen  out  1  tlast was asserted on the final accepted beat.
- early_last  out  1  tlast arrived before the final chunk.
- data_in  axi_stream_if #(.DATA_WIDTH(AXI_DATA_WIDTH))  slave side: block drives tready; samples tvalid, tdata, tlast.

Behaviour:
- Reset (rst=1 at a posedge):
  - state=IDLE, chunk_iter=0, len_q=0.
  - vec=0, last_seen=0, early_last=0, ready=0, tready=0.
  - Reset asserted mid-read abandons the read: no ready pulse; the next start begins fresh.
- Length latch: len_q = min(vec_length, MAX_VEC_LENGTH) on accepted start.
- Chunk arithmetic:
  - total = ceil(len_q / AXI_DATA_WIDTH), computed at width $clog2(MAX_CHUNKS+1), where MAX_CHUNKS = ceil(MAX_VEC_LENGTH / AXI_DATA_WIDTH).
  - last_chunk = (chunk_iter == total-1).
- States:
  - IDLE:
    - tready=0.
    - On start: latch len_q; clear vec, last_seen and early_last.
    - Next state: DONE if len_q==0, else READ.
    - Start while in READ or DONE is ignored.
  - READ:
    - tready=1 for the whole state.
    - Beat accepted when tvalid&&tready: write vec[chunk_iter*W +: W] = tdata, masked so bits >= len_q are 0.
    - Slice bits beyond MAX_VEC_LENGTH are dropped.
    - Accepted beat with last_chunk: last_seen<=tlast; go to DONE; chunk_iter holds.
    - Accepted beat with tlast && !last_chunk: early_last<=1; go to DONE; unread chunks stay 0.
    - Any other accepted beat: chunk_iter++ and stay in READ.
    - tvalid=0: hold all state; no timeout.
  - DONE:
    - ready=1 for exactly one cycle, then IDLE.
    - vec and flags hold their values until the next accepted start clears them.
- Latency:
  - start at cycle 0 gives tready=1 from cycle 1.
  - With continuous tvalid, N chunks are accepted on cycles 1..N; ready=1 on cycle N+1.
  - len_q==0 gives ready=1 on cycle 1 with no beats consumed.
- Simultaneous events:
  - start during DONE is ignored; it must be re-asserted in IDLE.
  - tlast on the final chunk is the normal case: last_seen=1, early_last=0.
- Beats offered outside READ are not accepted (tready=0); the upstream source holds them.
- No combinational path from tvalid to tready.

Decomposition:
- Package axi_vector_pkg:
  - state_t enum {STATE__IDLE, STATE__READ_CHUNK, STATE__DONE}, 2 bits.
  - Function for ceil-div chunk count, shared with the writer side.
- One sub-module: vector_tail_mask.
  - Combinational; parameters MAX_VEC_LENGTH, AXI_DATA_WIDTH.
  - Inputs: chunk_iter, len_q. Output: W-bit keep mask for the current slice.

Test Plan (MAX_VEC_LENGTH=10, AXI_DATA_WIDTH=4):
- vec_length=10, beats 0xA, 0x5, 0xF with tlast on the 3rd:
  - vec=10'b11_0101_1010; ready pulses 4 cycles after start; last_seen=1; early_last=0.
- vec_length=6, beats 0x3, 0xF, no tlast:
  - vec=10'b00_1111_0011 masks to 10'b00_0011_0011 (bits 6..7 zeroed); last_seen=0; exactly 2 beats consumed.
- vec_length=0:
  - ready on cycle 1; vec=0; tready stays 0 throughout.
- vec_length=10, beat 0x7 with tlast:
  - early_last=1; vec=10'h007; ready the next cycle; the 2nd and 3rd beats are not consumed.
- vec_length=8, tvalid toggled 1,0,0,1:
  - chunk_iter advances only on handshake cycles; ready 1 cycle after the 2nd accepted beat.
- rst=1 mid-read after 1 of 3 beats:
  - all outputs 0 and state IDLE next cycle; a fresh start with vec_length=4 and beat 0x9 gives vec=10'h009.
